// File: rtl/serial_byte_loader_pkg.sv
// ============================================================================
// Module : serial_byte_loader_pkg
// Brief  : Shared FSM state encoding, frame constants and parity helper.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package serial_byte_loader_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1,
        PAR  = 2'd2,
        STOP = 2'd3
    } state_e;

    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;

    // True when the XOR over data and parity bit does not match the selected sense.
    function automatic logic parity_bad(input logic data_xor,
                                        input logic par_bit,
                                        input logic odd);
        return (data_xor ^ par_bit) != odd;
    endfunction

endpackage

`default_nettype wire

// File: rtl/serial_byte_loader_shift_in_reg.sv
// ============================================================================
// Module : shift_in_reg
// Brief  : WIDTH-bit register with single indexed bit write and async clear.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module shift_in_reg #(
    parameter int WIDTH = 8,
    parameter int IDX_W = $clog2(WIDTH + 1)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             we_i,
    input  logic [IDX_W-1:0] idx_i,
    input  logic             bit_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] q_d;

    always_comb begin
        q_d = q_q;
        for (int i = 0; i < WIDTH; i++) begin
            if (we_i && (idx_i == IDX_W'(i))) begin
                q_d[i] = bit_i;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q_o = q_q;

endmodule

`default_nettype wire

// File: rtl/serial_byte_loader.sv
// ============================================================================
// Module : serial_byte_loader
// Brief  : Framed serial receiver feeding a D-latch bank with word + E pulse.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module serial_byte_loader
    import serial_byte_loader_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int PARITY_EN  = 1,
    parameter int PARITY_ODD = 0
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             sin_i,
    input  logic             svalid_i,
    output logic [WIDTH-1:0] d_o,
    output logic             e_o,
    output logic             busy_o,
    output logic             ferr_o,
    output logic             perr_o
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             perr_flag_q, perr_flag_d;
    logic [WIDTH-1:0] d_q, d_d;
    logic             e_q, e_d;
    logic             ferr_q, ferr_d;
    logic             perr_q, perr_d;
    logic             shift_we;
    logic [WIDTH-1:0] shift_q;

    shift_in_reg #(
        .WIDTH (WIDTH),
        .IDX_W (CNT_W)
    ) u_shift (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .we_i   (shift_we),
        .idx_i  (cnt_q),
        .bit_i  (sin_i),
        .q_o    (shift_q)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        perr_flag_d = perr_flag_q;
        d_d         = d_q;
        e_d         = 1'b0;
        ferr_d      = 1'b0;
        perr_d      = 1'b0;
        shift_we    = 1'b0;
        if (svalid_i) begin
            case (state_q)
                IDLE: begin
                    if (sin_i == START_BIT) begin
                        state_d     = DATA;
                        cnt_d       = '0;
                        perr_flag_d = 1'b0;
                    end
                end
                DATA: begin
                    shift_we = 1'b1;
                    // Exit on the last bit so the counter never reaches WIDTH.
                    if (cnt_q == CNT_W'(WIDTH - 1)) begin
                        state_d = (PARITY_EN != 0) ? PAR : STOP;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                PAR: begin
                    perr_flag_d = parity_bad(^shift_q, sin_i, (PARITY_ODD != 0));
                    state_d     = STOP;
                end
                STOP: begin
                    state_d = IDLE;
                    if (sin_i != STOP_BIT) begin
                        ferr_d = 1'b1;
                    end else if (perr_flag_q) begin
                        perr_d = 1'b1;
                    end else begin
                        d_d = shift_q;
                        e_d = 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            perr_flag_q <= 1'b0;
            d_q         <= '0;
            e_q         <= 1'b0;
            ferr_q      <= 1'b0;
            perr_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            perr_flag_q <= perr_flag_d;
            d_q         <= d_d;
            e_q         <= e_d;
            ferr_q      <= ferr_d;
            perr_q      <= perr_d;
        end
    end

    assign d_o    = d_q;
    assign e_o    = e_q;
    assign ferr_o = ferr_q;
    assign perr_o = perr_q;
    assign busy_o = (state_q != IDLE);

endmodule

`default_nettype wire
